sram_scan_bridge: RTL

Parametrised serial-scan access port to one of NUM_MEM synchronous SRAM macros. It is the multi-bank, burst-capable successor to the single-IMEM scan wrapper. A host shifts in a header (r/w, channel, count, start address) and then streams write data in, or streams read data out, one word per burst step on scan_clk. It is used by the tapeout testbench and bring-up to preload and dump IMEM/DMEM banks without a divided clock.

---
 rtl/sram_scan_bridge.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_scan_bridge.sv
// rtl/sram_scan_bridge.sv - serial scan access port to NUM_MEM synchronous SRAM banks
module sram_scan_bridge #(
  parameter int N_ADDR  = 16,
  parameter int N_CNT   = 16,
  parameter int N_DATA  = 32,
  parameter int NUM_MEM = 4,
  parameter int RD_LAT  = 1
) (
  input  logic                        scan_clk,
  input  logic                        scan_rst,
  input  logic                        scan_en,
  input  logic                        scan_in,
  output logic                        scan_out,
  output logic                        scan_busy,
  output logic                        scan_done,
  output logic [NUM_MEM-1:0]          mem_ce,
  output logic                        mem_we,
  output logic [N_ADDR-1:0]           mem_addr,
  output logic [N_DATA-1:0]           mem_din,
  input  logic [NUM_MEM*N_DATA-1:0]   mem_dout
);

  localparam int CH_BITS = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam int HDR_W   = 1 + CH_BITS + N_CNT + N_ADDR;
  localparam int MAX_CNT = (HDR_W > N_DATA) ? ((HDR_W > RD_LAT) ? HDR_W : RD_LAT)
                                            : ((N_DATA > RD_LAT) ? N_DATA : RD_LAT);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RISSUE = 3'd4;
  localparam logic [2:0] S_RWAIT  = 3'd5;
  localparam logic [2:0] S_RSHIFT = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [HDR_W-2:0]    hdr_q, hdr_d;
  logic [N_DATA-2:0]   wdata_q, wdata_d;
  logic [N_DATA-1:1]   rdata_q, rdata_d;
  logic [CH_BITS-1:0]  chan_q, chan_d;
  logic [N_CNT-1:0]    rem_q, rem_d;
  logic [N_ADDR-1:0]   addr_q, addr_d;
  logic [N_ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic [N_DATA-1:0]   mem_din_q, mem_din_d;
  logic                scan_out_q, scan_out_d;

  // Incoming bit lands in the MSB so the first bit shifted ends up at index 0.
  logic [HDR_W-1:0]    hdr_shift;
  logic [N_DATA-1:0]   wdata_shift;
  logic                hdr_rw;
  logic [CH_BITS-1:0]  hdr_chan;
  logic [N_CNT-1:0]    hdr_cnt;
  logic [N_ADDR-1:0]   hdr_addr;

  assign hdr_shift   = {scan_in, hdr_q};
  assign wdata_shift = {scan_in, wdata_q};
  assign hdr_rw      = hdr_shift[0];
  assign hdr_chan    = hdr_shift[CH_BITS:1];
  assign hdr_cnt     = hdr_shift[CH_BITS+N_CNT:CH_BITS+1];
  assign hdr_addr    = hdr_shift[HDR_W-1:CH_BITS+N_CNT+1];

  logic [NUM_MEM-1:0]  ce_sel;
  logic [N_DATA-1:0]   rd_slice;

  // Bank decode: an out-of-range channel selects nothing and reads as zero.
  always_comb begin
    ce_sel   = '0;
    rd_slice = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      if (chan_q == CH_BITS'(i)) begin
        ce_sel[i] = 1'b1;
        rd_slice  = mem_dout[i*N_DATA +: N_DATA];
      end
    end
  end

  // Frame sequencing: header, then per-word data transfer and memory access.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    hdr_d      = hdr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    chan_d     = chan_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    scan_out_d = scan_out_q;

    case (state_q)
      S_IDLE: begin
        if (scan_en) begin
          hdr_d    = hdr_shift[HDR_W-1:1];
          bitcnt_d = CNT_W'(1);
          state_d  = S_HDR;
        end
      end
      S_HDR: begin
        if (scan_en) begin
          hdr_d = hdr_shift[HDR_W-1:1];
          if (bitcnt_q == CNT_W'(HDR_W - 1)) begin
            bitcnt_d = '0;
            chan_d   = hdr_chan;
            rem_d    = hdr_cnt;
            addr_d   = hdr_addr;
            if (hdr_cnt == '0)  state_d = S_DONE;
            else if (hdr_rw)    state_d = S_WDATA;
            else                state_d = S_RISSUE;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      S_WDATA: begin
        if (scan_en) begin
          wdata_d = wdata_shift[N_DATA-1:1];
          if (bitcnt_q == CNT_W'(N_DATA - 1)) begin
            bitcnt_d  = '0;
            mem_din_d = wdata_shift;
            state_d   = S_WRITE;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + N_ADDR'(1);
        rem_d   = rem_q - N_CNT'(1);
        state_d = (rem_q == N_CNT'(1)) ? S_DONE : S_WDATA;
      end
      S_RISSUE: begin
        bitcnt_d = '0;
        state_d  = S_RWAIT;
      end
      S_RWAIT: begin
        if (bitcnt_q == CNT_W'(RD_LAT - 1)) begin
          rdata_d    = rd_slice[N_DATA-1:1];
          scan_out_d = rd_slice[0];
          bitcnt_d   = '0;
          state_d    = S_RSHIFT;
        end else begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      S_RSHIFT: begin
        if (scan_en) begin
          if (bitcnt_q == CNT_W'(N_DATA - 1)) begin
            scan_out_d = 1'b0;
            bitcnt_d   = '0;
            addr_d     = addr_q + N_ADDR'(1);
            rem_d      = rem_q - N_CNT'(1);
            state_d    = (rem_q == N_CNT'(1)) ? S_DONE : S_RISSUE;
          end else begin
            scan_out_d = rdata_q[1];
            rdata_d    = {1'b0, rdata_q[N_DATA-1:2]};
            bitcnt_d   = bitcnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The bus address is only refreshed when an access is about to start, so it
    // holds its last value between accesses.
    if (state_d == S_WRITE || state_d == S_RISSUE) begin
      mem_addr_d = addr_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge scan_clk) begin
    if (scan_rst) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      hdr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      chan_q     <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      scan_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      hdr_q      <= hdr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      chan_q     <= chan_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      scan_out_q <= scan_out_d;
    end
  end

  assign scan_out  = scan_out_q;
  assign scan_busy = (state_q != S_IDLE);
  assign scan_done = (state_q == S_DONE);
  assign mem_ce    = (state_q == S_WRITE || state_q == S_RISSUE) ? ce_sel : '0;
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule
